return_change_sequencer: RTL and testbench
==========================================

// Module: return_change_sequencer
// PURPOSE
//  Sequences coin return for the vending machine. On a return trigger, or after an inactivity
//  timeout, it latches the registered balance and tells the state block to clear it.
//  It then pays the balance out greedily, one coin per valid/ready handshake, to the coin hopper.
//  Sits between the balance/state registers and the hopper driver; owns every return-side timing.
// PARAMETERS
//  TOTAL_BITS   31    width of balance/remaining arithmetic (matches kTotalBits)
//  COIN0_VAL    100   smallest returnable coin value
//  COIN1_VAL    500   middle coin value
//  COIN2_VAL    1000  largest coin value (COIN2_VAL > COIN1_VAL > COIN0_VAL > 0)
//  WAIT_CYCLES  10    idle cycles with nonzero balance before auto-return (>=1)
// PORTS
//  clk               in   1           single clock, all logic on posedge
//  reset             in   1           synchronous, active-high reset
//  i_trigger_return  in   1           user return request, level sampled each cycle
//  i_activity        in   1           coin insert / item select seen this cycle
//  i_balance         in   TOTAL_BITS  current registered balance
//  i_coin_ready      in   1           hopper accepts the presented coin
//  o_clear_balance   out  1           1-cycle pulse: state block zeroes balance
//  o_coin_valid      out  1           coin request presented to hopper
//  o_coin_sel        out  3           one-hot {COIN2,COIN1,COIN0}; 0 when !o_coin_valid
//  o_busy            out  1           high in every state except IDLE
//  o_return_done     out  1           1-cycle pulse at end of a return sequence
//  o_remainder       out  TOTAL_BITS  undispensable residue of last return (< COIN0_VAL)
//  o_coins_out       out  16          saturating count of coins dispensed since reset
// BEHAVIOUR
//  Reset values: all outputs 0, FSM=IDLE, timer=WAIT_CYCLES, remaining=0.
//  A reset in any state, including mid-handshake, drops o_coin_valid the next edge.
//   No partial coin is counted.
//  FSM states: IDLE, LATCH, SELECT, DISPENSE, DONE.
//  IDLE:
//   - i_activity reloads timer to WAIT_CYCLES.
//   - Otherwise, if i_balance!=0, timer decrements. Timer holds at WAIT_CYCLES when balance==0.
//   - start = i_trigger_return | (timer==1 && !i_activity && i_balance!=0).
//   - On start -> LATCH.
//  LATCH:
//   - remaining <= i_balance; o_clear_balance=1 this cycle only.
//   - If i_balance==0 -> DONE, else -> SELECT.
//  SELECT (1 cycle):
//   - Choose the largest COINk_VAL <= remaining.
//   - None fits -> DONE.
//   - Otherwise register o_coin_sel, set o_coin_valid, -> DISPENSE.
//  DISPENSE:
//   - o_coin_valid and o_coin_sel are held stable until i_coin_ready is sampled high.
//   - On handshake: remaining <= remaining - value; o_coins_out++ (saturates at 16'hFFFF);
//     valid drops; -> SELECT.
//   - Minimum 2 cycles per coin.
//  DONE:
//   - o_return_done=1 for one cycle; o_remainder <= remaining; timer reloads; -> IDLE.
//  Ignored while o_busy: i_trigger_return and i_activity. Triggers are not queued.
//  Arithmetic:
//   - Subtraction is never issued when value > remaining, so no underflow.
//   - Comparisons are unsigned at TOTAL_BITS.
//  Latency: trigger at edge N -> o_clear_balance at N+1 -> first o_coin_valid at N+3.
// TESTING
//  1. i_balance=1700, trigger, ready tied high -> coins 1000,500,100,100 in order;
//     done pulse; remainder 0; coins_out=4.
//  2. i_balance=500, ready low 5 cycles after valid -> valid/sel=3'b010 held all 5 cycles;
//     exactly one coin counted.
//  3. i_balance=150, trigger -> one COIN0 (sel=3'b001); o_remainder=50.
//  4. i_balance=600, no activity/trigger -> auto-return starts WAIT_CYCLES=10 cycles later;
//     activity at cycle 5 restarts the count.
//  5. i_balance=0, trigger -> clear pulse, done pulse 2 cycles later, o_coin_valid never high.
//  6. reset asserted during DISPENSE -> next cycle valid=0, busy=0, coins_out=0;
//     a subsequent 100 return works normally.

Source files
------------

// File: rtl/return_change_sequencer.sv
// Coin-return sequencer: latches the balance on a trigger or inactivity timeout, clears it,
// then pays it out greedily one coin per valid/ready handshake to the hopper.
module return_change_sequencer #(
    parameter int unsigned TOTAL_BITS  = 31,
    parameter int unsigned COIN0_VAL   = 100,
    parameter int unsigned COIN1_VAL   = 500,
    parameter int unsigned COIN2_VAL   = 1000,
    parameter int unsigned WAIT_CYCLES = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_trigger_return,
    input  logic                  i_activity,
    input  logic [TOTAL_BITS-1:0] i_balance,
    input  logic                  i_coin_ready,
    output logic                  o_clear_balance,
    output logic                  o_coin_valid,
    output logic [2:0]            o_coin_sel,
    output logic                  o_busy,
    output logic                  o_return_done,
    output logic [TOTAL_BITS-1:0] o_remainder,
    output logic [15:0]           o_coins_out
);

    localparam int unsigned TimerBits = $clog2(WAIT_CYCLES + 1);
    localparam logic [TimerBits-1:0]  TimerLoad = TimerBits'(WAIT_CYCLES);
    localparam logic [TimerBits-1:0]  TimerOne  = TimerBits'(1);
    localparam logic [TOTAL_BITS-1:0] Coin0     = TOTAL_BITS'(COIN0_VAL);
    localparam logic [TOTAL_BITS-1:0] Coin1     = TOTAL_BITS'(COIN1_VAL);
    localparam logic [TOTAL_BITS-1:0] Coin2     = TOTAL_BITS'(COIN2_VAL);

    typedef enum logic [2:0] {StIdle, StLatch, StSelect, StDispense, StDone} state_e;

    state_e                 state_q, state_d;
    logic [TimerBits-1:0]   timer_q, timer_d;
    logic [TOTAL_BITS-1:0]  remaining_q, remaining_d;
    logic                   valid_q, valid_d;
    logic [2:0]             sel_q, sel_d;
    logic                   done_q, done_d;
    logic [TOTAL_BITS-1:0]  remainder_q, remainder_d;
    logic [15:0]            coins_q, coins_d;

    logic                   balance_nz;
    logic                   start;
    logic                   handshake;
    logic [2:0]             fit_sel;
    logic [TOTAL_BITS-1:0]  sel_value;

    assign balance_nz = (i_balance != '0);
    assign start      = i_trigger_return |
                        ((timer_q == TimerOne) && !i_activity && balance_nz);
    // valid is always high in DISPENSE, so ready alone completes the handshake there
    assign handshake  = (state_q == StDispense) && i_coin_ready;

    always_comb begin
        fit_sel = 3'b000;
        if (remaining_q >= Coin2) begin
            fit_sel = 3'b100;
        end else if (remaining_q >= Coin1) begin
            fit_sel = 3'b010;
        end else if (remaining_q >= Coin0) begin
            fit_sel = 3'b001;
        end
    end

    always_comb begin
        sel_value = '0;
        unique case (sel_q)
            3'b100:  sel_value = Coin2;
            3'b010:  sel_value = Coin1;
            3'b001:  sel_value = Coin0;
            default: sel_value = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (start) state_d = StLatch;
            StLatch:    state_d = balance_nz ? StSelect : StDone;
            StSelect:   state_d = (fit_sel == 3'b000) ? StDone : StDispense;
            StDispense: if (i_coin_ready) state_d = StSelect;
            StDone:     state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        o_clear_balance = (state_q == StLatch);
        o_busy          = (state_q != StIdle);
    end

    // Datapath next-state
    always_comb begin
        timer_d     = timer_q;
        remaining_d = remaining_q;
        valid_d     = valid_q;
        sel_d       = sel_q;
        done_d      = 1'b0;
        remainder_d = remainder_q;
        coins_d     = coins_q;

        unique case (state_q)
            StIdle: begin
                if (i_activity || !balance_nz) begin
                    timer_d = TimerLoad;
                end else if (timer_q > TimerOne) begin
                    timer_d = timer_q - TimerOne;
                end
            end
            StLatch: remaining_d = i_balance;
            StSelect: begin
                if (fit_sel != 3'b000) begin
                    valid_d = 1'b1;
                    sel_d   = fit_sel;
                end
            end
            StDispense: begin
                if (handshake) begin
                    remaining_d = remaining_q - sel_value;
                    valid_d     = 1'b0;
                    sel_d       = 3'b000;
                    if (coins_q != 16'hFFFF) begin
                        coins_d = coins_q + 16'd1;
                    end
                end
            end
            StDone: begin
                done_d      = 1'b1;
                remainder_d = remaining_q;
                timer_d     = TimerLoad;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q     <= TimerLoad;
            remaining_q <= '0;
            valid_q     <= 1'b0;
            sel_q       <= 3'b000;
            done_q      <= 1'b0;
            remainder_q <= '0;
            coins_q     <= '0;
        end else begin
            timer_q     <= timer_d;
            remaining_q <= remaining_d;
            valid_q     <= valid_d;
            sel_q       <= sel_d;
            done_q      <= done_d;
            remainder_q <= remainder_d;
            coins_q     <= coins_d;
        end
    end

    assign o_coin_valid  = valid_q;
    assign o_coin_sel    = sel_q;
    assign o_return_done = done_q;
    assign o_remainder   = remainder_q;
    assign o_coins_out   = coins_q;

endmodule

// File: tb/tb_return_change_sequencer.sv
// Directed bench for return_change_sequencer; models the balance register clearing on
// o_clear_balance and a hopper with programmable ready delay.
module tb_return_change_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_trigger_return;
    logic        i_activity;
    logic [30:0] i_balance;
    logic        i_coin_ready;
    logic        o_clear_balance;
    logic        o_coin_valid;
    logic [2:0]  o_coin_sel;
    logic        o_busy;
    logic        o_return_done;
    logic [30:0] o_remainder;
    logic [15:0] o_coins_out;

    int checks = 0;
    int failures = 0;

    logic [2:0] coin_log [0:7];
    int  coin_n;
    int  clear_cycle;
    int  first_valid;
    int  done_cycle;
    int  valid_cycles;
    int  hold_viol;
    bit  done_seen;
    bit  valid_any;

    always #5 clk = ~clk;

    return_change_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .i_trigger_return (i_trigger_return),
        .i_activity       (i_activity),
        .i_balance        (i_balance),
        .i_coin_ready     (i_coin_ready),
        .o_clear_balance  (o_clear_balance),
        .o_coin_valid     (o_coin_valid),
        .o_coin_sel       (o_coin_sel),
        .o_busy           (o_busy),
        .o_return_done    (o_return_done),
        .o_remainder      (o_remainder),
        .o_coins_out      (o_coins_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus driver: runs one return sequence and records what the hopper saw.
    task automatic run_seq(input bit trig, input int act_cycle, input int ready_delay,
                           input int max_cycles);
        int wait_cnt = 0;
        bit pending = 1'b0;
        bit pv = 1'b0;
        bit pr = 1'b0;
        logic [2:0] ps = 3'b000;
        coin_n = 0; clear_cycle = -1; first_valid = -1; done_cycle = -1;
        valid_cycles = 0; hold_viol = 0; done_seen = 1'b0; valid_any = 1'b0;
        i_trigger_return = trig;
        i_coin_ready = (ready_delay == 0);
        for (int cyc = 1; cyc <= max_cycles; cyc++) begin
            i_activity = (cyc == act_cycle);
            tick();
            i_trigger_return = 1'b0;
            i_activity = 1'b0;
            if (pending) begin
                i_balance = '0;
                pending = 1'b0;
            end
            if (o_clear_balance) begin
                pending = 1'b1;
                if (clear_cycle < 0) clear_cycle = cyc;
            end
            if (pv && !pr && (!o_coin_valid || o_coin_sel !== ps)) hold_viol++;
            if (!o_coin_valid && o_coin_sel !== 3'b000) hold_viol++;
            if (o_coin_valid) begin
                valid_any = 1'b1;
                valid_cycles++;
                if (first_valid < 0) first_valid = cyc;
                if (!pv || pr) begin
                    if (coin_n < 8) coin_log[coin_n] = o_coin_sel;
                    coin_n++;
                    wait_cnt = 0;
                end
                if (wait_cnt >= ready_delay) begin
                    i_coin_ready = 1'b1;
                end else begin
                    i_coin_ready = 1'b0;
                    wait_cnt++;
                end
            end else begin
                i_coin_ready = (ready_delay == 0);
            end
            pv = o_coin_valid;
            ps = o_coin_sel;
            pr = i_coin_ready;
            if (o_return_done) begin
                done_seen = 1'b1;
                done_cycle = cyc;
                break;
            end
        end
        i_coin_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        i_trigger_return = 1'b0;
        i_activity = 1'b0;
        i_balance = '0;
        i_coin_ready = 1'b0;
        tick();
        tick();
        checks++;
        if ({o_coin_valid, o_coin_sel, o_busy, o_return_done, o_clear_balance} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=0",
                     {o_coin_valid, o_coin_sel, o_busy, o_return_done, o_clear_balance});
        end
        checks++;
        if (o_coins_out !== 16'd0 || o_remainder !== 31'd0) begin
            failures++;
            $display("FAIL reset_counts coins=%0d rem=%0d want 0/0", o_coins_out, o_remainder);
        end
        reset = 1'b0;
    endtask

    task automatic test_change_1700();
        logic [2:0] exp_sel [0:3];
        exp_sel[0] = 3'b100; exp_sel[1] = 3'b010; exp_sel[2] = 3'b001; exp_sel[3] = 3'b001;
        i_balance = 31'd1700;
        run_seq(1'b1, 0, 0, 60);
        checks++;
        if (!done_seen || done_cycle != 12) begin
            failures++;
            $display("FAIL t1_done seen=%0b cycle=%0d want 1/12", done_seen, done_cycle);
        end
        checks++;
        if (clear_cycle != 1 || first_valid != 3) begin
            failures++;
            $display("FAIL t1_latency clear=%0d valid=%0d want 1/3", clear_cycle, first_valid);
        end
        checks++;
        if (coin_n != 4) begin
            failures++;
            $display("FAIL t1_coin_count got=%0d want=4", coin_n);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (coin_log[k] !== exp_sel[k]) begin
                failures++;
                $display("FAIL t1_coin%0d got=%b want=%b", k, coin_log[k], exp_sel[k]);
            end
        end
        checks++;
        if (o_remainder !== 31'd0 || o_coins_out !== 16'd4 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL t1_final rem=%0d coins=%0d busy=%b want 0/4/0",
                     o_remainder, o_coins_out, o_busy);
        end
    endtask

    task automatic test_backpressure();
        i_balance = 31'd500;
        run_seq(1'b1, 0, 5, 60);
        checks++;
        if (coin_n != 1 || coin_log[0] !== 3'b010) begin
            failures++;
            $display("FAIL t2_coin n=%0d sel=%b want 1/010", coin_n, coin_log[0]);
        end
        checks++;
        if (valid_cycles != 6 || hold_viol != 0) begin
            failures++;
            $display("FAIL t2_hold valid_cycles=%0d viol=%0d want 6/0", valid_cycles, hold_viol);
        end
        checks++;
        if (!done_seen || o_coins_out !== 16'd5) begin
            failures++;
            $display("FAIL t2_count done=%0b coins=%0d want 1/5", done_seen, o_coins_out);
        end
    endtask

    task automatic test_remainder();
        i_balance = 31'd150;
        run_seq(1'b1, 0, 0, 40);
        checks++;
        if (coin_n != 1 || coin_log[0] !== 3'b001) begin
            failures++;
            $display("FAIL t3_coin n=%0d sel=%b want 1/001", coin_n, coin_log[0]);
        end
        checks++;
        if (!done_seen || o_remainder !== 31'd50 || o_coins_out !== 16'd6) begin
            failures++;
            $display("FAIL t3_rem done=%0b rem=%0d coins=%0d want 1/50/6",
                     done_seen, o_remainder, o_coins_out);
        end
    endtask

    task automatic test_zero_balance();
        i_balance = 31'd0;
        run_seq(1'b1, 0, 0, 20);
        checks++;
        if (clear_cycle != 1 || done_cycle != 3) begin
            failures++;
            $display("FAIL t5_timing clear=%0d done=%0d want 1/3", clear_cycle, done_cycle);
        end
        checks++;
        if (valid_any || o_remainder !== 31'd0 || o_coins_out !== 16'd6) begin
            failures++;
            $display("FAIL t5_state valid_seen=%0b rem=%0d coins=%0d want 0/0/6",
                     valid_any, o_remainder, o_coins_out);
        end
    endtask

    task automatic test_timeout();
        i_balance = 31'd600;
        run_seq(1'b0, 0, 0, 60);
        checks++;
        if (clear_cycle != 10 || !done_seen) begin
            failures++;
            $display("FAIL t4_auto clear=%0d done=%0b want 10/1", clear_cycle, done_seen);
        end
        checks++;
        if (coin_n != 2 || coin_log[0] !== 3'b010 || coin_log[1] !== 3'b001) begin
            failures++;
            $display("FAIL t4_coins n=%0d c0=%b c1=%b want 2/010/001",
                     coin_n, coin_log[0], coin_log[1]);
        end
        i_balance = 31'd600;
        run_seq(1'b0, 5, 0, 60);
        checks++;
        if (clear_cycle != 15 || !done_seen || o_coins_out !== 16'd10) begin
            failures++;
            $display("FAIL t4_restart clear=%0d done=%0b coins=%0d want 15/1/10",
                     clear_cycle, done_seen, o_coins_out);
        end
    endtask

    task automatic test_reset_mid_dispense();
        i_balance = 31'd500;
        i_coin_ready = 1'b0;
        i_trigger_return = 1'b1;
        tick();
        i_trigger_return = 1'b0;
        tick();
        i_balance = '0;
        tick();
        checks++;
        if (o_coin_valid !== 1'b1 || o_coin_sel !== 3'b010) begin
            failures++;
            $display("FAIL t6_pre valid=%b sel=%b want 1/010", o_coin_valid, o_coin_sel);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (o_coin_valid !== 1'b0 || o_busy !== 1'b0 || o_coins_out !== 16'd0 ||
            o_coin_sel !== 3'b000) begin
            failures++;
            $display("FAIL t6_reset valid=%b busy=%b coins=%0d sel=%b want 0/0/0/000",
                     o_coin_valid, o_busy, o_coins_out, o_coin_sel);
        end
        i_balance = 31'd100;
        run_seq(1'b1, 0, 0, 40);
        checks++;
        if (!done_seen || coin_n != 1 || coin_log[0] !== 3'b001 || o_coins_out !== 16'd1 ||
            o_remainder !== 31'd0) begin
            failures++;
            $display("FAIL t6_after done=%0b n=%0d sel=%b coins=%0d rem=%0d want 1/1/001/1/0",
                     done_seen, coin_n, coin_log[0], o_coins_out, o_remainder);
        end
    endtask

    initial begin
        test_reset();
        test_change_1700();
        test_backpressure();
        test_remainder();
        test_zero_balance();
        test_timeout();
        test_reset_mid_dispense();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
